// File: rtl/datapath_pkg.sv
// Shared constants for the pipelined datapath: default widths and ALU function-select codes.
package datapath_pkg;

    localparam int DATA_W_DEF    = 64;
    localparam int REG_DEPTH_DEF = 32;
    localparam int RAM_DEPTH_DEF = 32;
    localparam int FS_W_DEF      = 5;

    localparam logic [FS_W_DEF-1:0] FS_PASSA = 5'b00000;
    localparam logic [FS_W_DEF-1:0] FS_ADD   = 5'b00100;
    localparam logic [FS_W_DEF-1:0] FS_SUB   = 5'b00101;
    localparam logic [FS_W_DEF-1:0] FS_AND   = 5'b01000;
    localparam logic [FS_W_DEF-1:0] FS_OR    = 5'b01100;
    localparam logic [FS_W_DEF-1:0] FS_XOR   = 5'b10000;
    localparam logic [FS_W_DEF-1:0] FS_NOTA  = 5'b10100;
    localparam logic [FS_W_DEF-1:0] FS_SHL   = 5'b11000;
    localparam logic [FS_W_DEF-1:0] FS_SHR   = 5'b11100;

endpackage

// File: rtl/datapath_pipe_alu.sv
// Combinational ALU for the E stage; undefined function selects yield result 0 and carry 0.
module alu_unit
    import datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FS_W   = FS_W_DEF
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    input  logic [FS_W-1:0]   fs_i,
    output logic [DATA_W-1:0] result_o,
    output logic              cout_o
);

    logic [FS_W_DEF-1:0] op;
    logic [DATA_W:0]     sum;

    assign op = FS_W_DEF'(fs_i);

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        result_o = '0;
        cout_o   = 1'b0;
        sum      = '0;
        case (op)
            FS_PASSA: result_o = a_i;
            FS_ADD: begin
                sum      = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
                result_o = sum[DATA_W-1:0];
                cout_o   = sum[DATA_W];
            end
            // Two's-complement subtract: the carry out is the no-borrow flag.
            FS_SUB: begin
                sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};
                result_o = sum[DATA_W-1:0];
                cout_o   = sum[DATA_W];
            end
            FS_AND:  result_o = a_i & b_i;
            FS_OR:   result_o = a_i | b_i;
            FS_XOR:  result_o = a_i ^ b_i;
            FS_NOTA: result_o = ~a_i;
            FS_SHL: begin
                result_o = {a_i[DATA_W-2:0], 1'b0};
                cout_o   = a_i[DATA_W-1];
            end
            FS_SHR: begin
                result_o = {1'b0, a_i[DATA_W-1:1]};
                cout_o   = a_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage (I/E) pipelined datapath: register file, ALU, RAM, writeback mux, hazard handling.
// Define DATAPATH_FORWARD_EN to bypass E-stage writeback into I-stage operands instead of stalling.
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REG_DEPTH = REG_DEPTH_DEF,
    parameter int RAM_DEPTH = RAM_DEPTH_DEF,
    parameter int FS_W      = FS_W_DEF,
    localparam int ADDR_W   = $clog2(REG_DEPTH),
    localparam int RAM_AW   = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FS_W-1:0]   FS,
    input  logic              Cin,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] data,
    input  logic              InSelect,
    input  logic              RegWrite,
    input  logic              RAMWrite,
    output logic [DATA_W-1:0] ALUout,
    output logic [DATA_W-1:0] RAMout,
    output logic              stat,
    output logic              Cout,
    output logic              out_valid
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] data;
        logic [FS_W-1:0]   fs;
        logic              cin;
        logic [ADDR_W-1:0] wr_addr;
        logic              insel;
        logic              regwrite;
        logic              ramwrite;
    } e_stage_t;

    logic [DATA_W-1:0] rf_q  [REG_DEPTH];
    logic [DATA_W-1:0] ram_q [RAM_DEPTH];

    e_stage_t          e_q, e_d;
    logic [DATA_W-1:0] alu_out_q, ram_out_q;
    logic              stat_q, cout_q, out_valid_q;

    logic [DATA_W-1:0] alu_res, wb_value, op_a, op_b;
    logic              alu_cout, stall, accept;
    logic [RAM_AW-1:0] ram_addr;

    alu_unit #(.DATA_W(DATA_W), .FS_W(FS_W)) u_alu (
        .a_i      (e_q.a),
        .b_i      (e_q.b),
        .cin_i    (e_q.cin),
        .fs_i     (e_q.fs),
        .result_o (alu_res),
        .cout_o   (alu_cout)
    );

    assign wb_value = e_q.insel ? alu_res : e_q.data;
    assign ram_addr = alu_res[RAM_AW-1:0];

`ifdef DATAPATH_FORWARD_EN
    // Each operand independently takes the value E is about to write back.
    assign op_a  = (e_q.valid && e_q.regwrite && rdAddrA == e_q.wr_addr) ? wb_value : rf_q[rdAddrA];
    assign op_b  = (e_q.valid && e_q.regwrite && rdAddrB == e_q.wr_addr) ? wb_value : rf_q[rdAddrB];
    assign stall = 1'b0;
`else
    assign op_a  = rf_q[rdAddrA];
    assign op_b  = rf_q[rdAddrB];
    assign stall = in_valid && e_q.valid && e_q.regwrite &&
                   (rdAddrA == e_q.wr_addr || rdAddrB == e_q.wr_addr);
`endif

    assign in_ready = ~reset & ~stall;
    assign accept   = in_valid & in_ready;

    always_comb begin
        e_d = '0;
        if (accept) begin
            e_d.valid    = 1'b1;
            e_d.a        = op_a;
            e_d.b        = op_b;
            e_d.data     = data;
            e_d.fs       = FS;
            e_d.cin      = Cin;
            e_d.wr_addr  = wrAddr;
            e_d.insel    = InSelect;
            e_d.regwrite = RegWrite;
            e_d.ramwrite = RAMWrite;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q         <= '0;
            alu_out_q   <= '0;
            ram_out_q   <= '0;
            stat_q      <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) rf_q[i] <= '0;
        end else begin
            e_q         <= e_d;
            out_valid_q <= e_q.valid;
            if (e_q.valid) begin
                alu_out_q <= alu_res;
                ram_out_q <= ram_q[ram_addr];
                stat_q    <= (alu_res == '0);
                cout_q    <= alu_cout;
                if (e_q.regwrite) rf_q[e_q.wr_addr] <= wb_value;
            end
        end
    end

    // NOTE: the RAM array has no reset so it maps onto plain memory; only the write is gated by reset.
    always_ff @(posedge clk) begin
        if (!reset && e_q.valid && e_q.ramwrite) ram_q[ram_addr] <= e_q.b;
    end

    assign ALUout    = alu_out_q;
    assign RAMout    = ram_out_q;
    assign stat      = stat_q;
    assign Cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench for datapath_pipe: an in-order reference model predicts every output strobe.
module tb_datapath_pipe;
    import datapath_pkg::*;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    FS;
    logic          Cin;
    logic [AW-1:0] rdAddrA, rdAddrB, wrAddr;
    logic [DW-1:0] data;
    logic          InSelect, RegWrite, RAMWrite;
    logic [DW-1:0] ALUout, RAMout;
    logic          stat, Cout, out_valid;

    always #5 clk = ~clk;

    datapath_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .FS(FS), .Cin(Cin), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .wrAddr(wrAddr),
        .data(data), .InSelect(InSelect), .RegWrite(RegWrite), .RAMWrite(RAMWrite),
        .ALUout(ALUout), .RAMout(RAMout), .stat(stat), .Cout(Cout), .out_valid(out_valid)
    );

    typedef struct {
        logic [DW-1:0] alu;
        logic [DW-1:0] ram;
        bit            ram_known;
        logic          stat;
        logic          cout;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] mrf  [32];
    logic [DW-1:0] mram [32];
    bit            mram_known [32];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_alu(input logic [4:0] fs, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic cin, output logic [DW-1:0] r, output logic c);
        logic [DW:0] wide;
        r = '0;
        c = 1'b0;
        case (fs)
            5'b00000: r = a;
            5'b00100: begin wide = DW'(a) + DW'(b); wide = {1'b0, a} + {1'b0, b} + (DW+1)'(cin); r = wide[DW-1:0]; c = wide[DW]; end
            5'b00101: begin r = a - b; c = (a >= b); end
            5'b01000: r = a & b;
            5'b01100: r = a | b;
            5'b10000: r = a ^ b;
            5'b10100: r = ~a;
            5'b11000: begin r = a << 1; c = a[DW-1]; end
            5'b11100: begin r = a >> 1; c = a[0]; end
            default: ;
        endcase
    endfunction

    task automatic go_idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        RegWrite = 1'b0;
        RAMWrite = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Present one instruction until accepted; the model executes it in program order.
    task automatic issue(input logic [4:0] fs, input logic cin, input int ra, input int rb, input int wa,
                         input logic [DW-1:0] d, input logic insel, input logic rw, input logic mw,
                         output int stalls);
        exp_t          e;
        logic [DW-1:0] a, b, r;
        logic          c;
        logic [4:0]    addr;
        @(negedge clk);
        in_valid = 1'b1; FS = fs; Cin = cin;
        rdAddrA = 5'(ra); rdAddrB = 5'(rb); wrAddr = 5'(wa);
        data = d; InSelect = insel; RegWrite = rw; RAMWrite = mw;
        stalls = 0;
        #1;
        while (!in_ready && stalls < 4) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        a = mrf[ra];
        b = mrf[rb];
        ref_alu(fs, a, b, cin, r, c);
        addr        = r[4:0];
        e.alu       = r;
        e.stat      = (r == '0);
        e.cout      = c;
        e.ram       = mram[addr];
        e.ram_known = mram_known[addr];
        if (mw) begin
            mram[addr]       = b;
            mram_known[addr] = 1'b1;
        end
        if (rw) mrf[wa] = insel ? r : d;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        go_idle(0);
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("ALUout", ALUout, e.alu);
                    check("stat", 64'(stat), 64'(e.stat));
                    check("Cout", 64'(Cout), 64'(e.cout));
                    if (e.ram_known) check("RAMout", RAMout, e.ram);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

    initial begin : stim
        int s, s2;
        logic [4:0] ops [8];
        ops = '{FS_AND, FS_OR, FS_XOR, FS_NOTA, FS_SHL, FS_SHR, FS_SUB, FS_ADD};
        for (int i = 0; i < 32; i++) begin
            mrf[i] = '0;
            mram[i] = '0;
            mram_known[i] = 1'b0;
        end
        reset = 1'b1; in_valid = 1'b0; FS = '0; Cin = 1'b0;
        rdAddrA = '0; rdAddrB = '0; wrAddr = '0; data = '0;
        InSelect = 1'b0; RegWrite = 1'b0; RAMWrite = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_ALUout", ALUout, 64'd0);
        check("reset_RAMout", RAMout, 64'd0);
        check("reset_stat_cout", {62'd0, stat, Cout}, 64'd0);
        reset = 1'b0;

        // Loads, then an ADD that reads the just-loaded R1.
        issue(FS_PASSA, 0, 0, 0, 0, 64'h0123456789ABCDEF, 0, 1, 0, s);
        issue(FS_PASSA, 0, 0, 0, 1, 64'h1111111111111111, 0, 1, 0, s);
        issue(FS_ADD,   0, 0, 1, 3, 64'd0, 1, 1, 0, s);
        drain("drain_t1");

        // Back-to-back dependent pair.
        issue(FS_ADD, 0, 0, 1, 3, 64'd0, 1, 1, 0, s);
        issue(FS_OR,  0, 3, 1, 4, 64'd0, 1, 1, 0, s2);
        check("no_hazard_stall", 64'(s), 64'd0);
`ifdef DATAPATH_FORWARD_EN
        check("hazard_stall_cycles", 64'(s2), 64'd0);
`else
        check("hazard_stall_cycles", 64'(s2), 64'd1);
`endif
        drain("drain_t2");

        // Carry-out wraparound, subtract with borrow, undefined opcode.
        issue(FS_PASSA, 0, 0, 0, 5, ALL1, 0, 1, 0, s);
        issue(FS_PASSA, 0, 0, 0, 6, 64'd1, 0, 1, 0, s);
        issue(FS_ADD,   0, 5, 6, 8, 64'd0, 1, 1, 0, s);
        issue(FS_ADD,   1, 6, 6, 8, 64'd0, 1, 1, 0, s);
        issue(FS_SUB,   0, 6, 5, 9, 64'd0, 1, 1, 0, s);
        issue(5'b11111, 0, 5, 6, 10, 64'd0, 1, 1, 0, s);
        drain("drain_t34");

        // Store to address 1 twice (second shows old data), then load it back.
        issue(FS_PASSA, 0, 6, 1, 0, 64'd0, 1, 0, 1, s);
        issue(FS_PASSA, 0, 6, 0, 0, 64'd0, 1, 0, 1, s);
        issue(FS_PASSA, 0, 6, 0, 0, 64'd0, 1, 0, 0, s);
        drain("drain_t5");

        // Random operands through every op, chaining through R13.
        issue(FS_PASSA, 0, 0, 0, 11, {$urandom, $urandom}, 0, 1, 0, s);
        issue(FS_PASSA, 0, 0, 0, 12, {$urandom, $urandom}, 0, 1, 0, s);
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], i[0], 11, 12, 13, 64'd0, 1, 1, 0, s);
            issue(ops[i], 1'b0, 13, 12, 13, 64'd0, 1, 1, 0, s);
        end
        drain("drain_rand");

        // Reset while a RegWrite/RAMWrite is in E: both writes must be dropped.
        @(negedge clk);
        in_valid = 1'b1; FS = FS_PASSA; Cin = 1'b0;
        rdAddrA = 5'd6; rdAddrB = 5'd5; wrAddr = 5'd7;
        data = 64'hDEAD; InSelect = 1'b0; RegWrite = 1'b1; RAMWrite = 1'b1;
        #1;
        check("pre_reset_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; RegWrite = 1'b0; RAMWrite = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_in_ready_mid", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_ALUout", ALUout, 64'd0);
        check("flush_RAMout", RAMout, 64'd0);
        check("flush_stat_cout", {62'd0, stat, Cout}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;

        issue(FS_PASSA, 0, 7, 0, 14, 64'd0, 1, 0, 0, s);
        issue(FS_PASSA, 0, 0, 0, 6, 64'd1, 0, 1, 0, s);
        issue(FS_PASSA, 0, 6, 0, 0, 64'd0, 1, 0, 0, s);
        drain("drain_t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
